// File: rtl/caja_fuerte_seq.sv
// caja_fuerte_seq: digit-entry combination lock with a retry limit and a timed lockout.
// unlocked/fail appear two edges after the final digit; lockout tracks the LOCKOUT state exactly.
//
// state   | meaning
// LOCKED  | idle, collecting digits into the entry buffer
// CHECK   | single cycle comparing the entry against the stored code
// OPEN    | safe open; code may be rewritten, lock_cmd relocks
// LOCKOUT | entry disabled for LOCK_CYCLES cycles
module caja_fuerte_seq #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0] CODE_INIT = 16'h1234,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYCLES = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               digit_valid,
    input  logic                               clear,
    input  logic                               lock_cmd,
    input  logic                               set_code,
    input  logic [N_DIGITS*DIGIT_W-1:0]        new_code,
    output logic                               unlocked,
    output logic                               fail,
    output logic                               lockout,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic [$clog2(N_DIGITS+1)-1:0]      digit_cnt
);

    localparam int CODE_W = N_DIGITS * DIGIT_W;
    localparam int TRW    = $clog2(MAX_TRIES + 1);
    localparam int CW     = $clog2(N_DIGITS + 1);
    localparam int TW     = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_LOCKED  = 2'd0,
        S_CHECK   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   entry_q, entry_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [TRW-1:0]      tries_q, tries_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                fail_pend_q, fail_pend_d;
    logic                unlocked_q, fail_q, lockout_q;

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        code_d      = code_q;
        tries_d     = tries_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        fail_pend_d = 1'b0;
        case (state_q)
            S_LOCKED: begin
                if (clear) begin
                    cnt_d   = '0;
                    entry_d = '0;
                end else if (digit_valid) begin
                    entry_d = (entry_q << DIGIT_W) | CODE_W'(digit);
                    if (cnt_q == CW'(N_DIGITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_CHECK: begin
                entry_d = '0;
                if (entry_q == code_q) begin
                    state_d = S_OPEN;
                    tries_d = TRW'(MAX_TRIES);
                end else begin
                    fail_pend_d = 1'b1;
                    tries_d     = tries_q - TRW'(1);
                    if (tries_q == TRW'(1)) begin
                        state_d = S_LOCKOUT;
                        timer_d = TW'(LOCK_CYCLES - 1);
                    end else begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_OPEN: begin
                if (set_code) code_d = new_code;
                if (lock_cmd) state_d = S_LOCKED;
            end
            S_LOCKOUT: begin
                // down-counter: terminal count ends the lockout
                if (timer_q == '0) begin
                    state_d = S_LOCKED;
                    tries_d = TRW'(MAX_TRIES);
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_LOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOCKED;
            entry_q     <= '0;
            code_q      <= CODE_INIT;
            tries_q     <= TRW'(MAX_TRIES);
            cnt_q       <= '0;
            timer_q     <= '0;
            fail_pend_q <= 1'b0;
            unlocked_q  <= 1'b0;
            fail_q      <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            code_q      <= code_d;
            tries_q     <= tries_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            fail_pend_q <= fail_pend_d;
            // unlocked rises one cycle into OPEN but drops on the relocking edge
            unlocked_q  <= (state_q == S_OPEN) && (state_d == S_OPEN);
            fail_q      <= fail_pend_q;
            lockout_q   <= (state_d == S_LOCKOUT);
        end
    end

    assign unlocked   = unlocked_q;
    assign fail       = fail_q;
    assign lockout    = lockout_q;
    assign tries_left = tries_q;
    assign digit_cnt  = cnt_q;

endmodule

// File: doc/caja_fuerte_seq.md
CAJA_FUERTE_SEQ -- requirements
Module: caja_fuerte_seq

Interface
REQ-001 Parameter N_DIGITS, default 4: number of digits in the combination (>=1).
REQ-002 Parameter DIGIT_W, default 4: bits per digit (>=1).
REQ-003 Parameter CODE_INIT, default 16'h1234: code loaded at reset; width N_DIGITS*DIGIT_W; first-entered digit is the most significant field.
REQ-004 Parameter MAX_TRIES, default 3: consecutive wrong codes before lockout (>=1).
REQ-005 Parameter LOCK_CYCLES, default 8: lockout duration in clock cycles (>=1).
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 digit  input  DIGIT_W  digit value; sampled only when digit_valid=1.
REQ-009 digit_valid  input  1  digit strobe; one digit accepted per cycle high.
REQ-010 clear  input  1  aborts a partial entry.
REQ-011 lock_cmd  input  1  relocks the safe from OPEN.
REQ-012 set_code  input  1  loads new_code into the code register while OPEN.
REQ-013 new_code  input  N_DIGITS*DIGIT_W  replacement combination.
REQ-014 unlocked  output  1  high while in OPEN.
REQ-015 fail  output  1  one-cycle pulse per wrong code.
REQ-016 lockout  output  1  high while in LOCKOUT.
REQ-017 tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts before lockout.
REQ-018 digit_cnt  output  $clog2(N_DIGITS+1)  digits accepted in current entry.

Function
REQ-019 States SHALL be LOCKED, CHECK, OPEN, LOCKOUT; all outputs registered.
REQ-020 In LOCKED, digit_valid=1 SHALL shift digit into the entry buffer and increment digit_cnt.
REQ-021 Acceptance of the N_DIGITS-th digit SHALL move LOCKED->CHECK and reset digit_cnt to 0.
REQ-022 In CHECK (exactly one cycle) entry==code SHALL move to OPEN and reload tries_left=MAX_TRIES.
REQ-023 In CHECK entry!=code SHALL pulse fail for exactly one cycle (the cycle after CHECK) and decrement tries_left.
REQ-024 If that decrement reaches 0, next state SHALL be LOCKOUT; otherwise LOCKED.
REQ-025 Latency: unlocked or fail SHALL assert on the 2nd rising edge after the edge accepting the final digit.
REQ-026 digit_valid, clear, set_code, lock_cmd SHALL be ignored in CHECK and LOCKOUT.
REQ-027 In LOCKED, clear=1 SHALL zero digit_cnt and the entry buffer, takes priority over same-cycle digit_valid, and SHALL NOT change tries_left.
REQ-028 LOCKOUT SHALL last exactly LOCK_CYCLES cycles, then go to LOCKED with tries_left=MAX_TRIES and digit_cnt=0.
REQ-029 In OPEN, digit_valid SHALL be ignored; set_code=1 SHALL write new_code to the code register.
REQ-030 In OPEN, lock_cmd=1 SHALL move to LOCKED; set_code and lock_cmd in the same cycle SHALL both take effect.
REQ-031 Code comparison SHALL be exact over all N_DIGITS*DIGIT_W bits.

Reset
REQ-032 rst=1 at any state, mid-entry or mid-lockout, SHALL on the next edge force LOCKED, code=CODE_INIT, tries_left=MAX_TRIES, digit_cnt=0, entry buffer 0, lockout timer 0.
REQ-033 Reset output values: unlocked=0, fail=0, lockout=0; rst has priority over all other inputs.

Verification
REQ-034 Digits 1,2,3,4 on consecutive cycles after reset -> unlocked=1 two edges after digit 4; tries_left=3.
REQ-035 Digits 1,2,3,5 -> fail pulses one cycle, tries_left=2, unlocked stays 0, digit_cnt=0.
REQ-036 Three wrong codes -> lockout=1 for exactly 8 cycles; digits during lockout ignored; then tries_left=3; code 1234 then opens.
REQ-037 Digits 1,2 then clear with digit_valid=1 same cycle -> digit_cnt=0, tries_left unchanged; 1,2,3,4 then opens.
REQ-038 In OPEN, set_code=1, lock_cmd=1, new_code=16'hABCD same cycle -> LOCKED; 1,2,3,4 fails; A,B,C,D opens.
REQ-039 rst asserted after 2 wrong codes and 3 digits of a third -> tries_left=3, digit_cnt=0, code=16'h1234.
